// File: rtl/zombie_lane_engine.sv
// -----------------------------------------------------------------------------
// zombie_lane_engine
//
// Game core for a lane-based "zombies walk left across the lawn" game.
// Each lane holds at most one zombie. Zombies spawn at SPAWN_X and step one
// pixel left on every movement tick. A zombie standing on END_OF_LAWN when
// a tick arrives loses the game. A projectile hit removes the zombie and adds
// a kill. Reaching KILLS_TO_WIN kills wins the game. The block also tells the
// VGA renderer whether the current pixel is covered by a live zombie.
//
// States (game_state is the one-hot state register itself):
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | after reset, waiting for start
//   RUN     | game in progress: divider counts, zombies move, spawns/hits
//   LOST    | a zombie reached the end of the lawn; everything frozen
//   WON     | kill target reached; everything frozen
//
// Ports:
//   clk, reset                 system clock, async active-high reset
//   start                      one-cycle pulse, (re)starts a game from any state
//   spawn_valid/lane/ready     spawn handshake, ready is combinational
//   hit_valid/lane             projectile hit report
//   hCount, vCount             current VGA pixel coordinate
//   zombie_pixel               pixel lies on a live zombie (combinational)
//   lane_active                per-lane zombie present flags
//   zombies_killed             saturating kill counter
//   game_state                 one-hot {WON, LOST, RUN, IDLE}
//   tick                       one-cycle pulse when zombies move
// -----------------------------------------------------------------------------
module zombie_lane_engine #(
    parameter int NUM_LANES    = 5,
    parameter int TICK_DIV     = 500000,
    parameter int LANE_TOP     = 160,
    parameter int LANE_HEIGHT  = 128,
    parameter int ZOMBIE_WIDTH = 100,
    parameter int SPAWN_X      = 700,
    parameter int END_OF_LAWN  = 0,
    parameter int KILLS_TO_WIN = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 spawn_valid,
    input  logic [2:0]           spawn_lane,
    output logic                 spawn_ready,
    input  logic                 hit_valid,
    input  logic [2:0]           hit_lane,
    input  logic [9:0]           hCount,
    input  logic [9:0]           vCount,
    output logic                 zombie_pixel,
    output logic [NUM_LANES-1:0] lane_active,
    output logic [15:0]          zombies_killed,
    output logic [3:0]           game_state,
    output logic                 tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0]  X_SPAWN  = 10'(SPAWN_X);
    localparam logic [9:0]  X_END    = 10'(END_OF_LAWN);
    localparam logic [15:0] KILL_WIN = 16'(KILLS_TO_WIN);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_RUN  = 4'b0010,
        ST_LOST = 4'b0100,
        ST_WON  = 4'b1000
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_LANES-1:0]   active_q, active_d;
    logic [9:0]             x_q [NUM_LANES];
    logic [9:0]             x_d [NUM_LANES];
    logic [15:0]            kills_q, kills_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   tick_w;
    logic                   kill_w;
    logic                   lost_w;

    // A start in the same cycle restarts the divider, so no movement happens.
    assign tick_w = (state_q == ST_RUN) && !start && (div_q == DIV_MAX);

    assign tick           = tick_w;
    assign game_state     = state_q;
    assign lane_active    = active_q;
    assign zombies_killed = kills_q;

    // Out-of-range lane indices never match a loop index, so they stay unready.
    always_comb begin
        spawn_ready = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if ((spawn_lane == 3'(i)) && !active_q[i]) begin
                spawn_ready = (state_q == ST_RUN);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        x_d      = x_q;
        kills_d  = kills_q;
        div_d    = div_q;
        kill_w   = 1'b0;
        lost_w   = 1'b0;

        if (start) begin
            state_d  = ST_RUN;
            active_d = '0;
            kills_d  = '0;
            div_d    = '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                x_d[i] = X_SPAWN;
            end
        end else if (state_q == ST_RUN) begin
            div_d = tick_w ? '0 : div_q + 1'b1;

            // Per lane: hit beats movement, so a zombie shot on the tick that
            // would have ended the game is simply removed. A spawn can never
            // collide with a hit because spawn_ready needs an empty lane.
            for (int i = 0; i < NUM_LANES; i++) begin
                if (hit_valid && (hit_lane == 3'(i)) && active_q[i]) begin
                    active_d[i] = 1'b0;
                    kill_w      = 1'b1;
                end else if (spawn_valid && spawn_ready && (spawn_lane == 3'(i))) begin
                    active_d[i] = 1'b1;
                    x_d[i]      = X_SPAWN;
                end else if (tick_w && active_q[i]) begin
                    if (x_q[i] == X_END) begin
                        lost_w = 1'b1;
                    end else begin
                        x_d[i] = x_q[i] - 10'd1;
                    end
                end
            end

            if (kill_w && (kills_q != 16'hFFFF)) begin
                kills_d = kills_q + 16'd1;
            end

            // Losing on another lane outranks winning in the same cycle.
            if (lost_w) begin
                state_d = ST_LOST;
            end else if (kill_w && (kills_d == KILL_WIN)) begin
                state_d = ST_WON;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            active_q <= '0;
            kills_q  <= '0;
            div_q    <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                x_q[i] <= X_SPAWN;
            end
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            kills_q  <= kills_d;
            div_q    <= div_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    // Bounds are widened to 11 bits so x + width never wraps past 1023.
    always_comb begin
        zombie_pixel = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (active_q[i]
                && ({1'b0, vCount} >= 11'(LANE_TOP + i * LANE_HEIGHT))
                && ({1'b0, vCount} <= 11'(LANE_TOP + (i + 1) * LANE_HEIGHT - 1))
                && ({1'b0, hCount} >= {1'b0, x_q[i]})
                && ({1'b0, hCount} <= ({1'b0, x_q[i]} + 11'(ZOMBIE_WIDTH - 1)))) begin
                zombie_pixel = 1'b1;
            end
        end
    end

endmodule
